i2c_target: RTL and testbench



---
 rtl/i2c_target_pkg.sv | 8 +
 rtl/i2c_sync_edge.sv | 17 +
 rtl/i2c_target.sv | 113 +++++++++++
 tb/tb_i2c_target.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: state encoding and ACK levels shared by the i2c_target slice
package i2c_target_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: 2-flop synchronizer plus history flop with rise/fall detection
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, h;
  // Reset to the idle-high bus level so release of reset creates no spurious edge
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, q, h} <= 3'b111;
    else {s1, q, h} <= {d, s1, q};
  assign rise = q & ~h;
  assign fall = ~q & h;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with a byte register bank; define I2C_TARGET_GENCALL_EN
// to also accept general-call writes (address 0x00) into the bank starting at register 0.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int NUM_REGS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
  input  logic [$clog2(NUM_REGS)-1:0] loc_addr,
  output logic [7:0] loc_rdata,
  output logic wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_index,
  output logic [7:0] wr_data,
  output logic busy
);
  localparam int AW = $clog2(NUM_REGS);
  state_t state, state_nx;
  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
  logic start, stop, full, nack, gc, addr_hit;
  logic rx, load, wr, ptr_ld, ptr_clr, ptr_inc, oe_nx;
  logic [2:0] cnt;
  logic [7:0] shreg;
  logic [AW-1:0] ptr;
  logic [7:0] regs [NUM_REGS];

  i2c_sync_edge u_scl (.clk(clk), .rst(rst), .d(scl_in), .q(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst(rst), .d(sda_in), .q(sda), .rise(sda_rise), .fall(sda_fall));

  assign start = sda_fall & scl;
  assign stop = sda_rise & scl;
`ifdef I2C_TARGET_GENCALL_EN
  assign gc = shreg == 8'h00;
`else
  assign gc = 1'b0;
`endif
  assign addr_hit = shreg[7:1] == TARGET_ADDR || gc;
  assign loc_rdata = regs[loc_addr];

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // START/STOP override any SCL edge seen in the same clock
  always_comb begin
    state_nx = state;
    if (start) state_nx = ADDR;
    else if (stop) state_nx = IDLE;
    else if (scl_fall)
      case (state)
        ADDR:      state_nx = !full ? ADDR : addr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK:  state_nx = shreg[0] ? RDATA : gc ? WDATA : PTR;
        PTR:       state_nx = full ? PTR_ACK : PTR;
        PTR_ACK:   state_nx = WDATA;
        WDATA:     state_nx = full ? WDATA_ACK : WDATA;
        WDATA_ACK: state_nx = WDATA;
        RDATA:     state_nx = full ? RACK : RDATA;
        RACK:      state_nx = nack == NACK ? IDLE : RDATA;
        default:   state_nx = state;
      endcase
  end

  always_comb begin
    rx = state == ADDR || state == PTR || state == WDATA;
    load = state_nx == RDATA && state != RDATA;
    wr = state == WDATA && state_nx == WDATA_ACK;
    ptr_ld = state == PTR && state_nx == PTR_ACK;
    ptr_clr = state == ADDR_ACK && state_nx == WDATA;
    ptr_inc = wr || (state == RDATA && state_nx == RACK);
    oe_nx = (start || stop) ? 1'b0 : !scl_fall ? sda_oe :
            (state_nx == ADDR_ACK || state_nx == PTR_ACK || state_nx == WDATA_ACK) ? ~ACK :
            state_nx == RDATA ? ~(state == RDATA ? shreg[7] : regs[ptr][7]) : 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sda_oe <= 1'b0;
      busy <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index <= '0;
      wr_data <= '0;
      shreg <= '0;
      cnt <= '0;
      full <= 1'b0;
      nack <= 1'b0;
      ptr <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      sda_oe <= oe_nx;
      wr_strobe <= wr;
      busy <= stop ? 1'b0 : (state == ADDR && state_nx != ADDR) ? state_nx == ADDR_ACK : busy;
      if (start || stop) begin
        cnt <= '0;
        full <= 1'b0;
      end else if (scl_rise && (rx || state == RDATA)) begin
        shreg <= rx ? {shreg[6:0], sda} : {shreg[6:0], 1'b0};
        cnt <= cnt + 3'd1;
        full <= cnt == 3'd7;
      end else if (scl_fall) full <= 1'b0;
      if (load) shreg <= regs[ptr];
      if (state == RACK && scl_rise) nack <= sda;
      if (wr) begin
        regs[ptr] <= shreg;
        wr_index <= ptr;
        wr_data <= shreg;
      end
      ptr <= ptr_ld ? shreg[AW-1:0] : ptr_clr ? '0 : ptr_inc ? ptr + AW'(1) : ptr;
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-level bench for i2c_target with an open-drain SDA model
module tb_i2c_target;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_c = 1'b1;
  logic sda_oe, wr_strobe, busy;
  logic [3:0] loc_addr = '0, wr_index;
  logic [7:0] loc_rdata, wr_data;
  logic sda_bus;
  logic [3:0] ws_i[$];
  logic [7:0] ws_d[$];
  int errors = 0, checks = 0;

  assign sda_bus = sda_c & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target dut (.clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata), .wr_strobe(wr_strobe), .wr_index(wr_index),
    .wr_data(wr_data), .busy(busy));

  always @(negedge clk)
    if (wr_strobe) begin
      ws_i.push_back(wr_index);
      ws_d.push_back(wr_data);
    end

  task automatic q();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_c = 1'b1; scl = 1'b1; q();
    sda_c = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_rstart();
    sda_c = 1'b1; q();
    scl = 1'b1; q();
    sda_c = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_c = 1'b0; q();
    scl = 1'b1; q();
    sda_c = 1'b1; q();
  endtask

  task automatic wb(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) begin
      sda_c = b[i]; q();
      scl = 1'b1; q(); q();
      scl = 1'b0;
    end
    sda_c = 1'b1; q();
    scl = 1'b1; q();
    a = sda_bus; q();
    scl = 1'b0; q();
  endtask

  task automatic rb(input logic ack_in, output logic [7:0] b);
    sda_c = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q();
      scl = 1'b1; q();
      b[i] = sda_bus; q();
      scl = 1'b0;
    end
    q();
    sda_c = ack_in; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; sda_c = 1'b1; q();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
    rst = 1'b0; q();
    for (int i = 0; i < 16; i++) begin
      loc_addr = 4'(i); #1;
      checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL reset_regs[%0d] got=%h exp=00", i, loc_rdata); end
    end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    ws_i.delete(); ws_d.delete();
    i2c_start();
    wb(8'h84, a0); wb(8'h03, a1); wb(8'hA5, a2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got=%b exp=1", busy); end
    wb(8'h5A, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL write_acks got=%b exp=0000", {a0, a1, a2, a3}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
    checks++;
    if (ws_i.size() != 2) begin errors++; $display("FAIL write_strobes got=%0d exp=2", ws_i.size()); end
    else if ({ws_i[0], ws_d[0], ws_i[1], ws_d[1]} !== {4'd3, 8'hA5, 4'd4, 8'h5A}) begin
      errors++; $display("FAIL write_strobe_vals got=(%0d,%h)(%0d,%h) exp=(3,a5)(4,5a)", ws_i[0], ws_d[0], ws_i[1], ws_d[1]);
    end
    loc_addr = 4'd3; #1;
    checks++; if (loc_rdata !== 8'hA5) begin errors++; $display("FAIL write_reg3 got=%h exp=a5", loc_rdata); end
    loc_addr = 4'd4; #1;
    checks++; if (loc_rdata !== 8'h5A) begin errors++; $display("FAIL write_reg4 got=%h exp=5a", loc_rdata); end
  endtask

  task automatic test_wrap();
    logic a;
    i2c_start();
    wb(8'h84, a); wb(8'h0F, a); wb(8'h11, a); wb(8'h22, a);
    i2c_stop();
    loc_addr = 4'd15; #1;
    checks++; if (loc_rdata !== 8'h11) begin errors++; $display("FAIL wrap_reg15 got=%h exp=11", loc_rdata); end
    loc_addr = 4'd0; #1;
    checks++; if (loc_rdata !== 8'h22) begin errors++; $display("FAIL wrap_reg0 got=%h exp=22", loc_rdata); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    i2c_start();
    wb(8'h84, a0); wb(8'h03, a1);
    i2c_rstart();
    wb(8'h85, a2);
    rb(1'b0, d0); rb(1'b1, d1);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL read_acks got=%b exp=000", {a0, a1, a2}); end
    checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL read_byte0 got=%h exp=a5", d0); end
    checks++; if (d1 !== 8'h5A) begin errors++; $display("FAIL read_byte1 got=%h exp=5a", d1); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_release got=%b exp=0", sda_oe); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_stop got=%b exp=0", busy); end
  endtask

  task automatic test_mismatch();
    logic a;
    ws_i.delete(); ws_d.delete();
    i2c_start();
    wb(8'h90, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL mismatch_ack got=%b exp=1", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy got=%b exp=0", busy); end
    wb(8'h66, a);
    i2c_stop();
    checks++; if (ws_i.size() != 0) begin errors++; $display("FAIL mismatch_strobes got=%0d exp=0", ws_i.size()); end
    i2c_start();
    wb(8'h00, a);
`ifdef I2C_TARGET_GENCALL_EN
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL gencall_ack got=%b exp=0", a); end
    wb(8'h77, a);
    i2c_stop();
    loc_addr = 4'd0; #1;
    checks++; if (loc_rdata !== 8'h77) begin errors++; $display("FAIL gencall_reg0 got=%h exp=77", loc_rdata); end
`else
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL gencall_nack got=%b exp=1", a); end
    i2c_stop();
`endif
  endtask

  task automatic test_rst_midread();
    logic a0, a1, a2, a3;
    i2c_start();
    wb(8'h84, a0); wb(8'h02, a0);
    i2c_rstart();
    wb(8'h85, a0);
    sda_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q(); scl = 1'b1; q(); q(); scl = 1'b0;
    end
    q(); scl = 1'b1; q();
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midread_drive got=%b exp=1", sda_oe); end
    loc_addr = 4'd3;
    rst = 1'b1; #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midread_rst_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_rst_busy got=%b exp=0", busy); end
    checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL midread_rst_reg3 got=%h exp=00", loc_rdata); end
    repeat (3) @(negedge clk);
    scl = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; q();
    ws_i.delete(); ws_d.delete();
    i2c_start();
    wb(8'h84, a1); wb(8'h01, a2); wb(8'h33, a3);
    i2c_stop();
    checks++; if ({a1, a2, a3} !== 3'b000) begin errors++; $display("FAIL postrst_acks got=%b exp=000", {a1, a2, a3}); end
    checks++;
    if (ws_i.size() != 1) begin errors++; $display("FAIL postrst_strobes got=%0d exp=1", ws_i.size()); end
    else if ({ws_i[0], ws_d[0]} !== {4'd1, 8'h33}) begin
      errors++; $display("FAIL postrst_strobe_val got=(%0d,%h) exp=(1,33)", ws_i[0], ws_d[0]);
    end
    loc_addr = 4'd1; #1;
    checks++; if (loc_rdata !== 8'h33) begin errors++; $display("FAIL postrst_reg1 got=%h exp=33", loc_rdata); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_read();
    test_mismatch();
    test_rst_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
